// File: rtl/dmr_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Holds the FSM state encoding, the wait-counter width and the address-legality helper.
package dmr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmr_state_t;

    localparam int DMR_WAIT_W = 4;
    localparam int DMR_DATA_W = 32;
    localparam int DMR_DEPTH  = 256;

    // A word address is legal only if aligned and every bit above the index field is zero.
    function automatic logic isBadAddr(input logic [31:0] addr, input int idxW);
        return (addr[1:0] != 2'b00) || ((addr >> (idxW + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmr_if.sv
// Request/response bundle between the MEM stage (master) and the data memory responder (slave).
// Valid/ready: a request transfers on a rising edge where req_valid and req_ready are both high;
// the master holds req_* stable until resp_valid, and resp_valid is a one-cycle strobe with no backpressure.
interface dmr_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/dmr_wait_counter.sv
// Loadable down-counter that paces the wait states of one memory access.
// Saturates at zero and reports zero combinationally.
module dmr_wait_counter
    import dmr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DMR_WAIT_W-1:0] loadVal,
    input  logic                  dec,
    output logic                  isZero
);

    logic [DMR_WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign isZero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle word memory serving MEM-stage loads and stores one at a time.
// Inserts WAIT_CYCLES wait states, answers with a one-cycle strobe and stalls the pipeline meanwhile.
module data_mem_responder
    import dmr_pkg::*;
#(
    parameter int DATA_W      = DMR_DATA_W,
    parameter int DEPTH       = DMR_DEPTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    dmr_if.slave       bus,
    output dmr_state_t dbgState
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DMR_WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : DMR_WAIT_W'(WAIT_CYCLES - 1);

    dmr_state_t        state, nextState;
    logic              cntLoad, cntDec, cntZero;
    logic              enterResp, reqReady, accept;

    logic [IDX_W-1:0]  reqIdx;
    logic              reqErr;

    logic              capWrite, capErr;
    logic [IDX_W-1:0]  capIdx;
    logic [DATA_W-1:0] capWdata;

    logic              accWrite, accErr;
    logic [IDX_W-1:0]  accIdx;
    logic [DATA_W-1:0] accWdata;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] respRdata;
    logic              respErr;

    assign reqIdx = bus.req_addr[IDX_W+1:2];
    assign reqErr = isBadAddr(bus.req_addr, IDX_W);
    assign accept = (state == IDLE) && bus.req_valid;

    dmr_wait_counter u_wait (
        .clk     (clk),
        .rst     (rst),
        .load    (cntLoad),
        .loadVal (WAIT_LOAD),
        .dec     (cntDec),
        .isZero  (cntZero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        cntLoad   = 1'b0;
        cntDec    = 1'b0;
        enterResp = 1'b0;
        reqReady  = 1'b0;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (bus.req_valid) begin
                    cntLoad = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end else begin
                        nextState = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cntZero) begin
                    nextState = RESP;
                    enterResp = 1'b1;
                end else begin
                    cntDec = 1'b1;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            capWrite <= 1'b0;
            capErr   <= 1'b0;
            capIdx   <= '0;
            capWdata <= '0;
        end else if (accept) begin
            capWrite <= bus.req_write;
            capErr   <= reqErr;
            capIdx   <= reqIdx;
            capWdata <= bus.req_wdata;
        end
    end

    // With zero wait states RESP is entered straight from IDLE, before the capture registers are valid.
    always_comb begin
        accWrite = capWrite;
        accErr   = capErr;
        accIdx   = capIdx;
        accWdata = capWdata;
        if (state == IDLE) begin
            accWrite = bus.req_write;
            accErr   = reqErr;
            accIdx   = reqIdx;
            accWdata = bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            respRdata <= '0;
            respErr   <= 1'b0;
        end else if (enterResp) begin
            respErr   <= accErr;
            respRdata <= (!accWrite && !accErr) ? mem[accIdx] : '0;
            if (accWrite && !accErr) begin
                mem[accIdx] <= accWdata;
            end
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = respRdata;
    assign bus.resp_err   = respErr;
    assign bus.stall      = bus.req_valid && (state != RESP);
    assign dbgState       = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
// Expected responses are queued at request time and popped when the response strobe appears.
module tb_data_mem_responder;
    import dmr_pkg::*;

    logic clk = 1'b0;
    logic rstA = 1'b0;
    logic rstB = 1'b0;
    dmr_state_t dbgA, dbgB;

    dmr_if #(.DATA_W(32)) ifA ();
    dmr_if #(.DATA_W(32)) ifB ();

    data_mem_responder #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .rst(rstA), .bus(ifA), .dbgState(dbgA)
    );
    data_mem_responder #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dutB (
        .clk(clk), .rst(rstB), .bus(ifB), .dbgState(dbgB)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic curSel = 1'b0;

    wire        obsValid = curSel ? ifB.resp_valid : ifA.resp_valid;
    wire        obsReady = curSel ? ifB.req_ready  : ifA.req_ready;
    wire        obsStall = curSel ? ifB.stall      : ifA.stall;
    wire        obsErr   = curSel ? ifB.resp_err   : ifA.resp_err;
    wire [31:0] obsData  = curSel ? ifB.resp_rdata : ifA.resp_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic sel, input logic v, input logic w,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            ifB.req_valid = v; ifB.req_write = w; ifB.req_addr = addr; ifB.req_wdata = wdata;
        end else begin
            ifA.req_valid = v; ifA.req_write = w; ifA.req_addr = addr; ifA.req_wdata = wdata;
        end
    endtask

    // One complete access: present, measure latency from the accepting edge, compare response.
    task automatic do_access(input string tag, input logic sel, input logic w,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic expErr, input logic [31:0] expData);
        int lat;
        int expLat;
        logic stallOk;
        logic [32:0] e;
        curSel = sel;
        expLat = sel ? 1 : 3;
        @(negedge clk);
        drive(sel, 1'b1, w, addr, wdata);
        exp_q.push_back({expErr, expData});
        #1;
        check({tag, ".ready"}, 64'(obsReady), 64'd1);
        check({tag, ".stall_req"}, 64'(obsStall), 64'd1);
        @(posedge clk);
        lat = 0;
        stallOk = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (obsValid) begin
                lat = k;
                break;
            end
            if (!obsStall) stallOk = 1'b0;
        end
        check({tag, ".latency"}, 64'(lat), 64'(expLat));
        check({tag, ".stall_busy"}, 64'(stallOk), 64'd1);
        e = exp_q.pop_front();
        check({tag, ".rdata"}, 64'(obsData), 64'(e[31:0]));
        check({tag, ".err"}, 64'(obsErr), 64'(e[32]));
        check({tag, ".stall_resp"}, 64'(obsStall), 64'd0);
        check({tag, ".ready_resp"}, 64'(obsReady), 64'd0);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] rv [8];
        logic [31:0] b2bAddr [3];
        logic [32:0] e;
        logic validOk;
        int got;

        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset held with a request present.
        repeat (3) @(negedge clk);
        check("rst.ready", 64'(ifA.req_ready), 64'd1);
        check("rst.resp_valid", 64'(ifA.resp_valid), 64'd0);
        check("rst.rdata", 64'(ifA.resp_rdata), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rstA = 1'b1;
        rstB = 1'b1;
        #1;
        check("rst.state", 64'(dbgA), 64'(IDLE));
        check("rst.ready_after", 64'(ifA.req_ready), 64'd1);
        check("rst.valid_after", 64'(ifA.resp_valid), 64'd0);
        do_access("rst.load0", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Store then load, two wait states.
        do_access("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        do_access("ld10", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Misaligned accesses.
        do_access("st13_mis", 1'b0, 1'b1, 32'h13, 32'h12345678, 1'b1, 32'h0);
        do_access("ld10_keep", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        do_access("ld11_mis", 1'b0, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0);

        // Out of range: index bits of 0x400 alias word 0, which must stay untouched.
        do_access("st0", 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 32'h0);
        do_access("st400_oor", 1'b0, 1'b1, 32'h400, 32'h22222222, 1'b1, 32'h0);
        do_access("ld0_keep", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h11111111);
        do_access("ld400_oor", 1'b0, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);
        do_access("ld_top", 1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0);

        // Randomised stores then loads over a private address window.
        for (int i = 0; i < 8; i++) begin
            rv[i] = $urandom_range(32'hFFFF, 0) ^ (32'(i) << 20);
            do_access("rnd_st", 1'b0, 1'b1, 32'h100 + 32'(i) * 4, rv[i], 1'b0, 32'h0);
        end
        for (int i = 7; i >= 0; i--) begin
            do_access("rnd_ld", 1'b0, 1'b0, 32'h100 + 32'(i) * 4, 32'h0, 1'b0, rv[i]);
        end

        // Zero wait states.
        do_access("w0.ld0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        do_access("w0.st8", 1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0, 32'h0);
        do_access("w0.ld8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hCAFEF00D);
        do_access("w0.ld_mis", 1'b1, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0);

        // Back-to-back loads with req_valid held: responses every second cycle.
        curSel = 1'b1;
        b2bAddr[0] = 32'h8;
        b2bAddr[1] = 32'h0;
        b2bAddr[2] = 32'h8;
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        got = 0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, b2bAddr[0], 32'h0);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            check("b2b.valid", 64'(ifB.resp_valid), 64'((cyc % 2 == 1) && (cyc < 7)));
            if (ifB.resp_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("b2b.rdata", 64'(ifB.resp_rdata), 64'(e[31:0]));
                got++;
                if (got < 3) drive(1'b1, 1'b1, 1'b0, b2bAddr[got], 32'h0);
                else drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        check("b2b.count", 64'(got), 64'd3);

        // Reset during BUSY abandons an uncommitted store.
        curSel = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        @(posedge clk);
        @(negedge clk);
        check("mid.busy", 64'(dbgA), 64'(BUSY));
        rstA = 1'b0;
        #1;
        check("mid.state", 64'(dbgA), 64'(IDLE));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        validOk = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (ifA.resp_valid) validOk = 1'b0;
        end
        rstA = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ifA.resp_valid) validOk = 1'b0;
        end
        check("mid.no_resp", 64'(validOk), 64'd1);
        do_access("mid.ld20", 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
        do_access("mid.ld10_clr", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage load/store requests. It replaces the zero-latency data store with a handshaked, multi-cycle word memory.
- Accepts one request at a time over a valid/ready interface and inserts a configurable number of wait states. It returns read data with a one-cycle response strobe and drives a stall to freeze the pipeline while an access is outstanding.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 256, number of words stored; power of two, at least 4.
- WAIT_CYCLES, 2, wait states between acceptance and response; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present; pipeline holds all req_* stable until resp_valid.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  DATA_W  store data.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  DATA_W  load data, valid with resp_valid.
- resp_err  output  1  misaligned or out-of-range access, valid with resp_valid.
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, wait counter = 0, captured request = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - All DEPTH words cleared to 0.
- Index and error:
  - word index = req_addr[log2(DEPTH)+1:2].
  - err = (req_addr[1:0] != 0) or (req_addr[31:log2(DEPTH)+2] != 0).
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture write, index, wdata and err.
  - Next state is BUSY with counter = WAIT_CYCLES-1, or RESP if WAIT_CYCLES = 0.
- BUSY:
  - req_ready = 0.
  - Counter decrements each cycle; go to RESP when the counter is 0.
- RESP:
  - req_ready = 0, resp_valid = 1, next state IDLE.
  - resp_rdata is registered and loaded on the edge entering RESP:
    - load with no error: mem[index];
    - store or error: 0.
  - resp_err is registered alongside resp_rdata.
- Store commit:
  - The write to mem[index] happens on the edge entering RESP, only if req_write = 1 and err = 0.
  - A load issued in a later transaction sees the stored value.
- Latency:
  - resp_valid is high exactly WAIT_CYCLES+1 cycles after the accepting edge.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- stall = req_valid and not resp_valid. It is combinational: high from the first request cycle through BUSY, and low in the RESP cycle so the pipeline advances with the response.
- Response backpressure: none; the pipeline always consumes resp_valid.
- Back-to-back requests: a request present during RESP is not accepted; it is accepted in the following IDLE cycle.
- Dropped requests: req_valid deasserting in BUSY is illegal; the responder still completes and responds.
- Reset mid-operation: the access is abandoned, a store not yet committed is not written, and no response is issued.
- Error handling: an erroneous store leaves memory unchanged. An erroneous load returns 0 with resp_err = 1.

Decomposition:
- Shared package dmr_pkg holds:
  - state enum dmr_state_t {IDLE, BUSY, RESP};
  - DMR_WAIT_W = 4 (counter width);
  - the default DATA_W and DEPTH constants.
- One sub-module, dmr_wait_counter: loadable down-counter with a zero flag, width DMR_WAIT_W.
- The memory array, FSM and error decode stay in the top module.

Test Plan:
- Reset: hold rst low 3 cycles with req_valid = 1 → req_ready = 0 is not allowed while in reset; after release state is IDLE, req_ready = 1, resp_valid = 0, and a load from 0x0 returns 0x00000000.
- Store then load, WAIT_CYCLES = 2:
  - store 0xDEADBEEF to 0x10 → resp_valid exactly 3 cycles after the accepting edge, stall high for the preceding cycles;
  - load from 0x10 → resp_rdata = 0xDEADBEEF, resp_err = 0.
- WAIT_CYCLES = 0: load accepted at edge N → resp_valid at cycle N+1; back-to-back loads accepted every 2 cycles.
- Misaligned store of 0x12345678 to 0x13 → resp_err = 1; a following load from 0x10 still returns the previous value; a misaligned load returns 0 with resp_err = 1.
- Out of range, DEPTH = 256: load from 0x400 → resp_err = 1, resp_rdata = 0; store to 0x400 modifies no word, so word 0 remains unchanged.
- Reset mid-BUSY: store 0xA5A5A5A5 to 0x20, assert rst during BUSY → no resp_valid, and a load from 0x20 after release returns 0.
